multicycle_controller: RTL
==========================

# multicycle_controller

Multi-cycle control unit for the MIPS-subset datapath. It replaces single-cycle combinational control with a state machine that sequences each instruction over 3–5+ cycles. It drives the existing datapath control strobes plus PC and IR write enables, and stalls on a ready handshake from data memory. It sits beside the datapath, taking opcode/func from the instruction register and the ALU `ZERO` flag.

## Interface
- `CNT_W`, default 32: width of the performance counters (used only with `MC_CTRL_PERF_CNT_EN`).
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: instruction bits [31:26].
- `func` in 6: instruction bits [5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: data memory has completed the current access.
- `ir_write` out 1: load the instruction register.
- `pc_write` out 1: load the PC.
- `reg_dst`, `jal_reg`, `pc_to_reg`, `alu_src`, `mem_to_reg`, `jump_sel`, `pc_jump`, `pc_src`, `reg_write`, `mem_read`, `mem_write` out 1 each: datapath selects and strobes, same meaning as the datapath inputs.
- `alu_cntrl` out 3: ALU operation.
- `illegal` out 1: undecodable instruction trapped; sticky until reset.
- `cycle_cnt`, `instr_cnt` out `CNT_W` each: present only with `MC_CTRL_PERF_CNT_EN`.

## Operation
- States: RST, FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP, TRAP.
- Reset:
  - While `rst` is high, the state is RST and every output is 0.
  - The first edge with `rst` low moves the state to FETCH.
- FETCH: `ir_write`=1. Next state is DECODE.
- DECODE:
  - Latch `opcode`/`func` into internal registers. All later states decode from these latched values.
  - Next state: R-type/addi/slti/lw/sw → EXEC; beq → BRANCH; j/jal/jr → JUMP; anything else → TRAP.
- EXEC:
  - `alu_src`=0 for R-type, 1 otherwise.
  - `alu_cntrl`:
    - add/addi/lw/sw: ADD=010
    - sub: SUB=110
    - and: AND=000
    - or: OR=001
    - slt/slti: SLT=111
  - Next state: lw/sw → MEM; else → WB.
  - Illegal R-type func (including jr decoded here) → TRAP.
- MEM:
  - `alu_cntrl`=ADD and `alu_src`=1 held.
  - `mem_read`=1 (lw) or `mem_write`=1 (sw), held until `mem_ready`=1.
  - On `mem_ready`: lw → WB; sw → FETCH with `pc_write`=1 that cycle.
- WB:
  - `reg_write`=1 and `pc_write`=1.
  - `reg_dst`=1 for R-type.
  - `mem_to_reg`=1 for lw.
  - The ALU inputs from EXEC/MEM are held.
  - Next state is FETCH.
- BRANCH:
  - `alu_cntrl`=SUB, `alu_src`=0, `pc_write`=1, `pc_src`=`zero` (combinational).
  - Next state is FETCH.
- JUMP:
  - `pc_write`=1, `pc_jump`=1.
  - `jump_sel`=1 for j/jal, 0 for jr.
  - jal additionally: `reg_write`=1, `jal_reg`=1, `pc_to_reg`=1.
  - Next state is FETCH.
- TRAP:
  - `illegal`=1; all strobes 0.
  - Remains in TRAP until `rst`.
- Every output not listed for a state is 0. Outputs are decoded from the state register and the latched opcode/func only, with one exception: `pc_src` in BRANCH follows `zero`.
- `mem_ready` is ignored outside MEM.

## Timing
- Cycles per instruction:
  - R-type/addi/slti: 4 (FETCH, DECODE, EXEC, WB).
  - lw: 5 + W, where W is the number of MEM cycles with `mem_ready`=0.
  - sw: 4 + W.
  - beq, j, jal, jr: 3.
- `pc_write` is asserted exactly once per instruction, in its final cycle.
- `reg_write` is asserted for at most one cycle per instruction.
- `rst` asserted mid-MEM: `mem_read`/`mem_write` are 0 from the first cycle `rst` is sampled high. The state is RST on the next edge and no `pc_write` occurs.
- `mem_ready` already 1 on MEM entry: MEM lasts exactly 1 cycle.

## Configuration
- `MC_CTRL_PERF_CNT_EN` defined:
  - `cycle_cnt` increments every cycle outside RST and TRAP.
  - `instr_cnt` increments on every cycle with `pc_write`=1.
  - Both clear on `rst` and wrap modulo 2^`CNT_W`.
- `MC_CTRL_PERF_CNT_EN` undefined: the counters and their ports do not exist. All other behaviour is identical.

## Structure
- Shared package `mc_ctrl_pkg` holds:
  - the state enum,
  - opcode constants (R=000000, addi=001000, slti=001010, lw=100011, sw=101011, beq=000100, j=000010, jal=000011),
  - func constants (add=100000, sub=100010, and=100100, or=100101, slt=101010, jr=001000),
  - ALU code constants.
- One sub-module, `alu_op_decode`: combinational mapping from (latched opcode, func) to `alu_cntrl` plus an illegal flag.

## Test plan
- add (opcode 0, func 100000) after reset → FETCH, DECODE, EXEC, WB. `alu_cntrl`=010 in EXEC. `reg_write`=`reg_dst`=`pc_write`=1 only in cycle 4.
- lw with `mem_ready` low for 2 MEM cycles → `mem_read`=1 for 3 cycles, then WB with `mem_to_reg`=1. Total 7 cycles.
- beq with `zero`=1, then with `zero`=0 → 3 cycles each, `pc_write`=1 in BRANCH. `pc_src`=1, then `pc_src`=0.
- jal → JUMP cycle has `pc_jump`=`jump_sel`=`reg_write`=`jal_reg`=`pc_to_reg`=1. jr → `pc_jump`=1, `jump_sel`=0.
- opcode 111111 → `illegal`=1 from the cycle after DECODE and stays 1 indefinitely with all strobes 0. `rst` clears it.
- sw in MEM with `mem_ready`=0, then `rst`=1 → `mem_write`=0 that cycle, no `pc_write`. Release → FETCH. With the macro defined: `cycle_cnt`, `instr_cnt` = 0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset controller.
package mc_ctrl_pkg;

   localparam int unsigned OP_W   = 6;
   localparam int unsigned FUNC_W = 6;
   localparam int unsigned ALU_W  = 3;

   typedef enum logic [3:0] {
      S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_JUMP, S_TRAP
   } state_t;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;
   localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

   localparam logic [FUNC_W-1:0] F_ADD = 6'b100000;
   localparam logic [FUNC_W-1:0] F_SUB = 6'b100010;
   localparam logic [FUNC_W-1:0] F_AND = 6'b100100;
   localparam logic [FUNC_W-1:0] F_OR  = 6'b100101;
   localparam logic [FUNC_W-1:0] F_SLT = 6'b101010;
   localparam logic [FUNC_W-1:0] F_JR  = 6'b001000;

   localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

   typedef struct packed {
      logic             ir_write;
      logic             pc_write;
      logic             reg_dst;
      logic             jal_reg;
      logic             pc_to_reg;
      logic             alu_src;
      logic             mem_to_reg;
      logic             jump_sel;
      logic             pc_jump;
      logic             pc_src;
      logic             reg_write;
      logic             mem_read;
      logic             mem_write;
      logic [ALU_W-1:0] alu_cntrl;
      logic             illegal;
   } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, control strobes out.
interface multicycle_controller_if import mc_ctrl_pkg::*; ();
   logic [OP_W-1:0]   opcode;
   logic [FUNC_W-1:0] func;
   logic              zero;
   logic              mem_ready;
   logic              ir_write;
   logic              pc_write;
   logic              reg_dst;
   logic              jal_reg;
   logic              pc_to_reg;
   logic              alu_src;
   logic              mem_to_reg;
   logic              jump_sel;
   logic              pc_jump;
   logic              pc_src;
   logic              reg_write;
   logic              mem_read;
   logic              mem_write;
   logic [ALU_W-1:0]  alu_cntrl;
   logic              illegal;

   modport master (
      input  opcode, func, zero, mem_ready,
      output ir_write, pc_write, reg_dst, jal_reg, pc_to_reg, alu_src, mem_to_reg,
             jump_sel, pc_jump, pc_src, reg_write, mem_read, mem_write, alu_cntrl, illegal
   );

   modport slave (
      output opcode, func, zero, mem_ready,
      input  ir_write, pc_write, reg_dst, jal_reg, pc_to_reg, alu_src, mem_to_reg,
             jump_sel, pc_jump, pc_src, reg_write, mem_read, mem_write, alu_cntrl, illegal
   );
endinterface

// File: rtl/alu_op_decode.sv
// Maps latched opcode/func to the ALU operation; flags combinations with no ALU meaning.
module alu_op_decode import mc_ctrl_pkg::*; (
   input  logic [OP_W-1:0]   opcode,
   input  logic [FUNC_W-1:0] func,
   output logic [ALU_W-1:0]  alu_cntrl,
   output logic              illegal
);

   always_comb begin
      alu_cntrl = ALU_AND;
      illegal   = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (func)
               F_ADD:   alu_cntrl = ALU_ADD;
               F_SUB:   alu_cntrl = ALU_SUB;
               F_AND:   alu_cntrl = ALU_AND;
               F_OR:    alu_cntrl = ALU_OR;
               F_SLT:   alu_cntrl = ALU_SLT;
               default: illegal   = 1'b1;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW: alu_cntrl = ALU_ADD;
         OP_SLTI:               alu_cntrl = ALU_SLT;
         default:               illegal   = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the MIPS-subset datapath.
// Optional performance counters enabled by defining MC_CTRL_PERF_CNT_EN.
module multicycle_controller import mc_ctrl_pkg::*; #(
   parameter int unsigned CNT_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   multicycle_controller_if.master  bus
`ifdef MC_CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]         cycle_cnt,
   output logic [CNT_W-1:0]         instr_cnt
`endif
);

   if (CNT_W == 0) begin : g_cnt_w_check
      $error("CNT_W must be at least 1");
   end

   state_t            state, state_nxt;
   logic [OP_W-1:0]   lat_op;
   logic [FUNC_W-1:0] lat_func;
   ctrl_t             ctrl;
   logic [ALU_W-1:0]  dec_alu;
   logic              dec_illegal;
   logic              is_r, is_lw, is_sw, is_jal;

   assign is_r   = (lat_op == OP_RTYPE);
   assign is_lw  = (lat_op == OP_LW);
   assign is_sw  = (lat_op == OP_SW);
   assign is_jal = (lat_op == OP_JAL);

   alu_op_decode u_alu_op_decode (
      .opcode    (lat_op),
      .func      (lat_func),
      .alu_cntrl (dec_alu),
      .illegal   (dec_illegal)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_RST;
      else     state <= state_nxt;
   end

   // Instruction fields are captured once so later states ignore IR changes.
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_op   <= '0;
         lat_func <= '0;
      end else if (state == S_DECODE) begin
         lat_op   <= bus.opcode;
         lat_func <= bus.func;
      end
   end

   always_comb begin
      state_nxt = state;
      ctrl      = '0;
      case (state)
         S_RST:    state_nxt = S_FETCH;
         S_FETCH: begin
            ctrl.ir_write = 1'b1;
            state_nxt     = S_DECODE;
         end
         S_DECODE: begin
            case (bus.opcode)
               OP_RTYPE:                       state_nxt = (bus.func == F_JR) ? S_JUMP : S_EXEC;
               OP_ADDI, OP_SLTI, OP_LW, OP_SW: state_nxt = S_EXEC;
               OP_BEQ:                         state_nxt = S_BRANCH;
               OP_J, OP_JAL:                   state_nxt = S_JUMP;
               default:                        state_nxt = S_TRAP;
            endcase
         end
         S_EXEC: begin
            ctrl.alu_src   = !is_r;
            ctrl.alu_cntrl = dec_alu;
            if (dec_illegal)          state_nxt = S_TRAP;
            else if (is_lw || is_sw)  state_nxt = S_MEM;
            else                      state_nxt = S_WB;
         end
         S_MEM: begin
            ctrl.alu_src   = 1'b1;
            ctrl.alu_cntrl = ALU_ADD;
            ctrl.mem_read  = is_lw;
            ctrl.mem_write = is_sw;
            if (bus.mem_ready) begin
               ctrl.pc_write = is_sw;
               state_nxt     = is_lw ? S_WB : S_FETCH;
            end
         end
         S_WB: begin
            ctrl.alu_src    = !is_r;
            ctrl.alu_cntrl  = dec_alu;
            ctrl.reg_write  = 1'b1;
            ctrl.pc_write   = 1'b1;
            ctrl.reg_dst    = is_r;
            ctrl.mem_to_reg = is_lw;
            state_nxt       = S_FETCH;
         end
         S_BRANCH: begin
            ctrl.alu_cntrl = ALU_SUB;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_src    = bus.zero;
            state_nxt      = S_FETCH;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_jump   = 1'b1;
            ctrl.jump_sel  = !is_r;
            ctrl.reg_write = is_jal;
            ctrl.jal_reg   = is_jal;
            ctrl.pc_to_reg = is_jal;
         end
         S_TRAP:   ctrl.illegal = 1'b1;
         default:  state_nxt = S_RST;
      endcase
      if (state == S_JUMP) state_nxt = S_FETCH;
      // Reset silences every strobe in the same cycle, before the state changes.
      if (rst) ctrl = '0;
   end

   assign bus.ir_write   = ctrl.ir_write;
   assign bus.pc_write   = ctrl.pc_write;
   assign bus.reg_dst    = ctrl.reg_dst;
   assign bus.jal_reg    = ctrl.jal_reg;
   assign bus.pc_to_reg  = ctrl.pc_to_reg;
   assign bus.alu_src    = ctrl.alu_src;
   assign bus.mem_to_reg = ctrl.mem_to_reg;
   assign bus.jump_sel   = ctrl.jump_sel;
   assign bus.pc_jump    = ctrl.pc_jump;
   assign bus.pc_src     = ctrl.pc_src;
   assign bus.reg_write  = ctrl.reg_write;
   assign bus.mem_read   = ctrl.mem_read;
   assign bus.mem_write  = ctrl.mem_write;
   assign bus.alu_cntrl  = ctrl.alu_cntrl;
   assign bus.illegal    = ctrl.illegal;

`ifdef MC_CTRL_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         if (state != S_RST && state != S_TRAP) cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (ctrl.pc_write)                     instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end
`endif

endmodule
